// File: rtl/cal_pkg.sv
// Shared types and calendar rules for the time-of-day / calendar controller.
package cal_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_MIN  = 3'd1,
    SET_HR   = 3'd2,
    SET_MON  = 3'd3,
    SET_DAY  = 3'd4,
    SET_YEAR = 3'd5
  } mode_e;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int MON_MOD  = 12;
  localparam int YEAR_MOD = 100;

  // Unknown month codes fall back to 31 so the day counter always has a sane limit.
  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
    logic [4:0] dim;
    case (month)
      4'd2:                     dim = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  dim = 5'd30;
      default:                  dim = 5'd31;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/cal_time_ctrl_mod_counter.sv
// Wrapping field counter: counts MIN .. MIN+modulus-1, with a parallel load that wins over increment.
module mod_counter #(
  parameter int W   = 6,
  parameter int MIN = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic [W-1:0] i_modulus,
  output logic [W-1:0] o_value,
  output logic [W-1:0] o_nxt,
  output logic         o_wrap
);

  localparam logic [W-1:0] MIN_V = W'(MIN);

  logic [W-1:0] r_value;
  logic [W-1:0] w_last;
  logic         w_at_last;

  // Compare with >= so a value stranded above a shrunken limit still wraps instead of running on.
  assign w_last    = MIN_V + i_modulus - W'(1);
  assign w_at_last = (r_value >= w_last);
  assign o_nxt     = w_at_last ? MIN_V : r_value + W'(1);
  assign o_wrap    = i_inc && w_at_last;
  assign o_value   = r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= MIN_V;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_inc) begin
      r_value <= o_nxt;
    end
  end

endmodule

// File: rtl/cal_time_ctrl.sv
// Time-of-day and calendar controller with button-driven set mode.
// Leap years, the year counter and the SET_YEAR state are enabled by defining CAL_LEAP_YEAR_EN.
module cal_time_ctrl
  import cal_pkg::*;
#(
  parameter int HR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       set_mode,
  input  logic       set_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hr,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic [2:0] mode,
  output logic       day_roll
);

  mode_e r_state, w_state_next;
  logic  r_day_roll;

  logic w_tick_en, w_sec_load, w_min_set, w_hr_set, w_mon_set, w_day_set, w_year_set;
  logic w_sec_inc, w_min_inc, w_hr_inc, w_day_inc, w_mon_inc, w_day_load;
  logic w_sec_wrap, w_min_wrap, w_hr_wrap, w_day_wrap, w_mon_wrap;
  logic [5:0] w_sec, w_min, w_sec_nxt, w_min_nxt;
  logic [4:0] w_hr, w_day, w_hr_nxt, w_day_nxt, w_dim_cur, w_dim_new;
  logic [3:0] w_mon, w_mon_nxt, w_mon_new;
  logic [6:0] w_year;
  logic       w_year_chg, w_leap_cur, w_leap_new;
  logic       w_unused;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (set_mode) begin
      case (r_state)
        RUN:      w_state_next = SET_MIN;
        SET_MIN:  w_state_next = SET_HR;
        SET_HR:   w_state_next = SET_MON;
        SET_MON:  w_state_next = SET_DAY;
`ifdef CAL_LEAP_YEAR_EN
        SET_DAY:  w_state_next = SET_YEAR;
`else
        SET_DAY:  w_state_next = RUN;
`endif
        default:  w_state_next = RUN;
      endcase
    end
  end

  // set_mode always wins: it suppresses both the tick and set_inc for that cycle.
  always_comb begin
    w_tick_en  = (r_state == RUN) && tick && !set_mode;
    w_sec_load = (r_state == RUN) && set_mode;
    w_min_set  = (r_state == SET_MIN)  && set_inc && !set_mode;
    w_hr_set   = (r_state == SET_HR)   && set_inc && !set_mode;
    w_mon_set  = (r_state == SET_MON)  && set_inc && !set_mode;
    w_day_set  = (r_state == SET_DAY)  && set_inc && !set_mode;
    w_year_set = (r_state == SET_YEAR) && set_inc && !set_mode;
  end

  // Carries only ripple on a RUN tick; set-state increments never propagate.
  assign w_sec_inc = w_tick_en;
  assign w_min_inc = (w_tick_en && w_sec_wrap) || w_min_set;
  assign w_hr_inc  = (w_tick_en && w_min_wrap) || w_hr_set;
  assign w_day_inc = (w_tick_en && w_hr_wrap)  || w_day_set;
  assign w_mon_inc = (w_tick_en && w_day_wrap) || w_mon_set;

  mod_counter #(.W(6), .MIN(0)) u_sec (
    .clk(clk), .rst(rst), .i_inc(w_sec_inc), .i_load(w_sec_load), .i_load_val(6'd0),
    .i_modulus(6'(SEC_MOD)), .o_value(w_sec), .o_nxt(w_sec_nxt), .o_wrap(w_sec_wrap)
  );

  mod_counter #(.W(6), .MIN(0)) u_min (
    .clk(clk), .rst(rst), .i_inc(w_min_inc), .i_load(1'b0), .i_load_val(6'd0),
    .i_modulus(6'(MIN_MOD)), .o_value(w_min), .o_nxt(w_min_nxt), .o_wrap(w_min_wrap)
  );

  mod_counter #(.W(5), .MIN(0)) u_hr (
    .clk(clk), .rst(rst), .i_inc(w_hr_inc), .i_load(1'b0), .i_load_val(5'd0),
    .i_modulus(5'(HR_MAX + 1)), .o_value(w_hr), .o_nxt(w_hr_nxt), .o_wrap(w_hr_wrap)
  );

  mod_counter #(.W(5), .MIN(1)) u_day (
    .clk(clk), .rst(rst), .i_inc(w_day_inc), .i_load(w_day_load), .i_load_val(w_dim_new),
    .i_modulus(w_dim_cur), .o_value(w_day), .o_nxt(w_day_nxt), .o_wrap(w_day_wrap)
  );

  mod_counter #(.W(4), .MIN(1)) u_mon (
    .clk(clk), .rst(rst), .i_inc(w_mon_inc), .i_load(1'b0), .i_load_val(4'd0),
    .i_modulus(4'(MON_MOD)), .o_value(w_mon), .o_nxt(w_mon_nxt), .o_wrap(w_mon_wrap)
  );

`ifdef CAL_LEAP_YEAR_EN
  logic       w_year_inc, w_year_wrap;
  logic [6:0] w_year_nxt, w_year_new;

  assign w_year_inc = (w_tick_en && w_mon_wrap) || w_year_set;

  mod_counter #(.W(7), .MIN(0)) u_year (
    .clk(clk), .rst(rst), .i_inc(w_year_inc), .i_load(1'b0), .i_load_val(7'd0),
    .i_modulus(7'(YEAR_MOD)), .o_value(w_year), .o_nxt(w_year_nxt), .o_wrap(w_year_wrap)
  );

  assign w_year_new = w_year_inc ? w_year_nxt : w_year;
  assign w_year_chg = w_year_inc;
  assign w_leap_cur = (w_year[1:0] == 2'b00);
  assign w_leap_new = (w_year_new[1:0] == 2'b00);
  assign w_unused   = ^{w_sec_nxt, w_min_nxt, w_hr_nxt, w_day_nxt, w_year_wrap, w_year_set};
`else
  assign w_year     = 7'd0;
  assign w_year_chg = 1'b0;
  assign w_leap_cur = 1'b0;
  assign w_leap_new = 1'b0;
  assign w_unused   = ^{w_sec_nxt, w_min_nxt, w_hr_nxt, w_day_nxt, w_mon_wrap, w_year_set};
`endif

  // Clamp looks at the month/year being written this cycle, so day lands in range together with them.
  assign w_mon_new  = w_mon_inc ? w_mon_nxt : w_mon;
  assign w_dim_cur  = days_in_month(w_mon, w_leap_cur);
  assign w_dim_new  = days_in_month(w_mon_new, w_leap_new);
  assign w_day_load = (w_mon_inc || w_year_chg) && !w_day_inc && (w_day > w_dim_new);

  always_ff @(posedge clk) begin
    if (rst) r_day_roll <= 1'b0;
    else     r_day_roll <= w_tick_en && w_day_wrap;
  end

  assign sec      = w_sec;
  assign min      = w_min;
  assign hr       = w_hr;
  assign day      = w_day;
  assign month    = w_mon;
  assign year     = w_year;
  assign mode     = r_state;
  assign day_roll = r_day_roll;

endmodule

// File: tb/tb_cal_time_ctrl.sv
// Directed bench for cal_time_ctrl; expectations are hand-computed calendar values.
module tb_cal_time_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       set_mode = 1'b0;
  logic       set_inc = 1'b0;
  logic [5:0] sec, min;
  logic [4:0] hr, day;
  logic [3:0] month;
  logic [6:0] year;
  logic [2:0] mode;
  logic       day_roll;

  int n_total = 0;
  int n_bad   = 0;

  cal_time_ctrl #(.HR_MAX(23)) dut (
    .clk(clk), .rst(rst), .tick(tick), .set_mode(set_mode), .set_inc(set_inc),
    .sec(sec), .min(min), .hr(hr), .day(day), .month(month), .year(year),
    .mode(mode), .day_roll(day_roll)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // One clock with the given pulses; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic t, input logic m, input logic i);
    tick = t; set_mode = m; set_inc = i;
    @(posedge clk); #1;
    tick = 0; set_mode = 0; set_inc = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic adv(input int n);
    repeat (n) cyc(1'b0, 1'b1, 1'b0);
  endtask

  // Starts from reset values in RUN, ends back in RUN with sec=0.
  task automatic preload(input int h, input int m, input int mo, input int d, input int y);
    adv(1); incs(m);
    adv(1); incs(h);
    adv(1); incs(mo - 1);
    adv(1); incs(d - 1);
`ifdef CAL_LEAP_YEAR_EN
    adv(1); incs(y);
`else
    if (y != 0) $display("note: year %0d ignored without leap support", y);
`endif
    adv(1);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_sec", sec, 0);
    check("rst_min", min, 0);
    check("rst_hr", hr, 0);
    check("rst_day", day, 1);
    check("rst_month", month, 1);
    check("rst_year", year, 0);
    check("rst_mode", mode, 0);
    check("rst_day_roll", day_roll, 0);

    // 60 ticks roll one minute
    ticks(59);
    check("t59_sec", sec, 59);
    check("t59_min", min, 0);
    ticks(1);
    check("t60_sec", sec, 0);
    check("t60_min", min, 1);
    check("t60_hr", hr, 0);
    check("t60_day", day, 1);
    check("t60_month", month, 1);
    cyc(1'b0, 1'b0, 1'b1);
    check("run_inc_min", min, 1);
    check("run_inc_mode", mode, 0);

    // 23:59:59 Jan 31 -> 00:00:00 Feb 1
    do_reset();
    preload(23, 59, 1, 31, 0);
    check("pre_mode", mode, 0);
    check("pre_hr", hr, 23);
    check("pre_min", min, 59);
    check("pre_day", day, 31);
    ticks(59);
    check("jan_sec59", sec, 59);
    check("jan_roll_lo", day_roll, 0);
    ticks(1);
    check("feb_sec", sec, 0);
    check("feb_min", min, 0);
    check("feb_hr", hr, 0);
    check("feb_day", day, 1);
    check("feb_month", month, 2);
    check("feb_roll_hi", day_roll, 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("feb_roll_drop", day_roll, 0);

    // Day 31 in March, then SET_MON inc to April clamps to 30
    do_reset();
    adv(3);
    check("clamp_mode_mon", mode, 3);
    incs(2);
    check("clamp_month3", month, 3);
    adv(1);
    incs(30);
    check("clamp_day31", day, 31);
    cyc(1'b1, 1'b0, 1'b0);
    check("setday_tick_day", day, 31);
    check("setday_tick_sec", sec, 0);
`ifdef CAL_LEAP_YEAR_EN
    adv(2);
`else
    adv(1);
`endif
    check("clamp_back_run", mode, 0);
    adv(3);
    check("clamp_mode_mon2", mode, 3);
    incs(1);
    check("clamp_month4", month, 4);
    check("clamp_day30", day, 30);

    // Dec 31 23:59:59 -> Jan 1
    do_reset();
    preload(23, 59, 12, 31, 0);
    ticks(60);
    check("ny_month", month, 1);
    check("ny_day", day, 1);
    check("ny_hr", hr, 0);
    check("ny_roll", day_roll, 1);
`ifdef CAL_LEAP_YEAR_EN
    check("ny_year", year, 1);
`else
    check("ny_year", year, 0);
`endif

    // February end-of-month
`ifdef CAL_LEAP_YEAR_EN
    do_reset();
    preload(23, 59, 2, 28, 4);
    check("leap_year4", year, 4);
    ticks(60);
    check("leap_day29", day, 29);
    check("leap_month2", month, 2);
    do_reset();
    preload(23, 59, 2, 28, 5);
    ticks(60);
    check("noleap_day1", day, 1);
    check("noleap_month3", month, 3);
`else
    do_reset();
    preload(23, 59, 2, 28, 0);
    ticks(60);
    check("feb28_day1", day, 1);
    check("feb28_month3", month, 3);
`endif

    // set_mode + set_inc together in SET_HR
    do_reset();
    adv(2);
    check("sim_mode_hr", mode, 2);
    incs(3);
    check("sim_hr3", hr, 3);
    cyc(1'b0, 1'b1, 1'b1);
    check("sim_mode_mon", mode, 3);
    check("sim_hr_hold", hr, 3);
    check("sim_month_hold", month, 1);

    // rst while in SET_DAY
    adv(1);
    check("rst_mid_mode", mode, 4);
    incs(2);
    check("rst_mid_day3", day, 3);
    do_reset();
    check("rst_mid_mode0", mode, 0);
    check("rst_mid_hr", hr, 0);
    check("rst_mid_day", day, 1);
    check("rst_mid_month", month, 1);
    check("rst_mid_min", min, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cal_time_ctrl.md
# cal_time_ctrl

Time-of-day and calendar controller for the lab clock. Chains seconds, minutes, hours, day-of-month and month counters from a one-cycle tick pulse. Provides a button-driven set-mode state machine that steps through the fields and increments the selected one. Owns month-length rules, including the day clamp on month change. Sits between the tick divider/button debouncers and the display/alarm logic.

## Interface
- `HR_MAX`, default 23: last hour value; hours wrap `HR_MAX`→0.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `tick`  in  1  one-cycle pulse, once per second.
- `set_mode`  in  1  one-cycle debounced pulse; advances the mode FSM.
- `set_inc`  in  1  one-cycle debounced pulse; increments the selected field in a set state.
- `sec`  out  6  seconds, 0–59.
- `min`  out  6  minutes, 0–59.
- `hr`  out  5  hours, 0–`HR_MAX`.
- `day`  out  5  day of month, 1–days_in_month.
- `month`  out  4  month, 1–12.
- `year`  out  7  year offset from 2000, 0–99.
- `mode`  out  3  current FSM state encoding, from the package enum.
- `day_roll`  out  1  one-cycle pulse on the cycle `day` wraps to 1 in RUN.

## Operation
- FSM states: RUN → SET_MIN → SET_HR → SET_MON → SET_DAY → (SET_YEAR if enabled) → RUN.
  - Each `set_mode` pulse advances one state.
- RUN behaviour on `tick`:
  - `sec` increments, wrapping 59→0.
  - On that wrap, `min` increments, wrapping 59→0.
  - On that wrap, `hr` increments, wrapping `HR_MAX`→0.
  - On that wrap, `day` increments, wrapping days_in_month→1, and `day_roll` is asserted.
  - On that wrap, `month` increments, wrapping 12→1.
  - With leap support, the 12→1 month wrap increments `year`, wrapping 99→0.
- days_in_month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - 28 for month 2 (29 if leap, see Configuration).
  - Any other month value maps to 31.
- Set states:
  - `tick` is ignored and no carries propagate.
  - `set_inc` increments only the selected field, with its own wrap (day wraps at days_in_month→1).
- Entering SET_MIN clears `sec` to 0.
- Day clamp: any time `month` or `year` changes and `day` > new days_in_month, `day` is loaded with days_in_month in the same cycle.
- Simultaneous `set_mode` and `set_inc`: `set_mode` wins and `set_inc` is dropped.
- `set_inc` in RUN has no effect.
- Arithmetic is unsigned. Field widths are fixed as listed. The next-value compare uses the current value against the modulus; there is no overflow into an unused code.

## Timing
- Reset values: `sec`=0, `min`=0, `hr`=0, `day`=1, `month`=1, `year`=0, `mode`=RUN, `day_roll`=0.
- All outputs are registered.
- An event on the `tick`/`set_inc`/`set_mode` input in cycle n is visible on the outputs in cycle n+1. The full carry chain resolves in that single cycle.
- `day_roll` is high for exactly the one cycle in which the new `day`=1 is presented.
- `rst` mid-set-operation returns to RUN with reset values next cycle and overrides all inputs.
- `tick` arriving on the same cycle as the `set_mode` that enters RUN is ignored. Counting resumes on the next `tick`.

## Configuration
- Macro `CAL_LEAP_YEAR_EN`.
- Defined:
  - `year` counts as described.
  - SET_YEAR state exists.
  - February has 29 days when `year[1:0]`==0.
  - Clamp also applies on a year change (Feb 29 → Feb 28).
- Undefined:
  - `year` is held at 0.
  - No SET_YEAR state; SET_DAY → RUN.
  - February is always 28.

## Structure
- Package `cal_pkg` holds:
  - `mode_e` enum.
  - Constants SEC_MOD=60, MIN_MOD=60, MON_MOD=12, YEAR_MOD=100.
  - Function `days_in_month(month, leap)`.
- Sub-module `mod_counter`:
  - Parameterised width, min value and modulus input.
  - Ports: increment, load, load value; outputs value and a wrap flag.
  - Instantiated once per field.
- Top level contains the FSM, carry/enable logic and clamp.

## Test plan
- Reset, then 60 ticks → `sec`=0, `min`=1, others at reset values.
- Preload 23:59:59, Jan 31 via set mode, then 1 tick → 00:00:00, Feb 1; `day_roll` pulses one cycle.
- Set `day`=31 in March, then SET_MON `set_inc` to April → `day`=30 on the same cycle `month`=4.
- Dec 31 23:59:59, 1 tick → Jan 1, with `year`+1 when `CAL_LEAP_YEAR_EN` is defined and `year` remaining 0 when it is undefined.
- `CAL_LEAP_YEAR_EN`, `year`=4, Feb 28 23:59:59, tick → Feb 29; with `year`=5 → Mar 1.
- `set_mode` and `set_inc` asserted in the same cycle in SET_HR → FSM goes to SET_MON and `hr` is unchanged. `rst` pulsed while in SET_DAY → RUN with all reset values.
